// File: rtl/elevator_controller_if.sv
// Call-panel bundle between the panel (master) and the car controller (slave).
interface elevator_controller_if;
  logic [4:0] floor_req;
  logic [4:0] floor_pos;
  logic       door_open;
  logic       dir_up;
  logic       dir_down;

  modport master (
    output floor_req,
    input  floor_pos,
    input  door_open,
    input  dir_up,
    input  dir_down
  );

  modport slave (
    input  floor_req,
    output floor_pos,
    output door_open,
    output dir_up,
    output dir_down
  );
endinterface

// File: rtl/elevator_controller.sv
// Five-floor SCAN elevator car: latches calls, moves one floor per FLOOR_CYCLES, opens door DOOR_CYCLES per stop.
// First move one cycle after a call; no backpressure, requests are absorbed into the pending set every cycle.
module elevator_controller #(
  parameter int FLOOR_CYCLES = 1,
  parameter int DOOR_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  elevator_controller_if.slave  bus
);

  localparam int TW = (FLOOR_CYCLES > 1) ? $clog2(FLOOR_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    DOOR = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [4:0]      pos, pos_n;
  logic [4:0]      pending, pending_n;
  logic [TW-1:0]   trav_cnt, trav_cnt_n;
  logic [DW-1:0]   door_cnt, door_cnt_n;
  logic            last_up, last_up_n;

  logic [4:0]      eff;
  logic [4:0]      below_mask, above_mask;
  logic [4:0]      pos_up, pos_dn;
  logic            here, above, below;
  logic            up_above, dn_below;
  logic            trav_done, door_done;

  // Masks rely on pos being one-hot: pos-1 selects every floor strictly below it.
  always_comb begin
    eff        = pending | bus.floor_req;
    below_mask = pos - 5'd1;
    above_mask = ~(pos | below_mask);
    here       = |(eff & pos);
    above      = |(eff & above_mask);
    below      = |(eff & below_mask);
    pos_up     = {pos[3:0], 1'b0};
    pos_dn     = {1'b0, pos[4:1]};
    up_above   = |(eff & ~(pos_up | (pos_up - 5'd1)));
    dn_below   = |(eff & (pos_dn - 5'd1));
    trav_done  = (trav_cnt == TW'(FLOOR_CYCLES - 1));
    door_done  = (door_cnt == DW'(DOOR_CYCLES - 1));
  end

  always_comb begin
    state_n    = state;
    pos_n      = pos;
    pending_n  = eff;
    trav_cnt_n = trav_cnt;
    door_cnt_n = door_cnt;
    last_up_n  = last_up;

    case (state)
      IDLE: begin
        trav_cnt_n = '0;
        door_cnt_n = '0;
        if (here) begin
          state_n   = DOOR;
          pending_n = eff & ~pos;
        end else if (above) begin
          state_n   = UP;
          last_up_n = 1'b1;
        end else if (below) begin
          state_n   = DOWN;
          last_up_n = 1'b0;
        end
      end

      UP: begin
        if (pos[4]) begin
          state_n    = IDLE;
          trav_cnt_n = '0;
        end else if (!trav_done) begin
          trav_cnt_n = trav_cnt + 1'b1;
        end else begin
          trav_cnt_n = '0;
          pos_n      = pos_up;
          if (|(eff & pos_up)) begin
            state_n    = DOOR;
            door_cnt_n = '0;
            pending_n  = eff & ~pos_up;
          end else if (!up_above) begin
            state_n = IDLE;
          end
        end
      end

      DOWN: begin
        if (pos[0]) begin
          state_n    = IDLE;
          trav_cnt_n = '0;
        end else if (!trav_done) begin
          trav_cnt_n = trav_cnt + 1'b1;
        end else begin
          trav_cnt_n = '0;
          pos_n      = pos_dn;
          if (|(eff & pos_dn)) begin
            state_n    = DOOR;
            door_cnt_n = '0;
            pending_n  = eff & ~pos_dn;
          end else if (!dn_below) begin
            state_n = IDLE;
          end
        end
      end

      DOOR: begin
        // Calls for the open floor are swallowed without extending the timer.
        pending_n = eff & ~pos;
        if (!door_done) begin
          door_cnt_n = door_cnt + 1'b1;
        end else begin
          door_cnt_n = '0;
          if (here) begin
            state_n = DOOR;
          end else if (last_up && above) begin
            state_n = UP;
          end else if (below) begin
            state_n   = DOWN;
            last_up_n = 1'b0;
          end else if (above) begin
            state_n   = UP;
            last_up_n = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pos      <= 5'b00001;
      pending  <= '0;
      trav_cnt <= '0;
      door_cnt <= '0;
      last_up  <= 1'b1;
    end else begin
      state    <= state_n;
      pos      <= pos_n;
      pending  <= pending_n;
      trav_cnt <= trav_cnt_n;
      door_cnt <= door_cnt_n;
      last_up  <= last_up_n;
    end
  end

  assign bus.floor_pos = pos;
  assign bus.door_open = (state == DOOR);
  assign bus.dir_up    = (state == UP);
  assign bus.dir_down  = (state == DOWN);

endmodule

// File: tb/tb_elevator_controller.sv
// Directed bench for elevator_controller; observed word is {floor_pos, door_open, dir_up, dir_down}.
module tb_elevator_controller;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [7:0] obs;

  elevator_controller_if bus();

  elevator_controller #(
    .FLOOR_CYCLES(1),
    .DOOR_CYCLES (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  assign obs = {bus.floor_pos, bus.door_open, bus.dir_up, bus.dir_down};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.floor_req = 5'b10000;
    tick();
    checks++;
    if (obs !== 8'b00001_000) begin
      errors++;
      $display("FAIL reset_held: got %b expected %b", obs, 8'b00001_000);
    end
    bus.floor_req = 5'b00000;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== 8'b00001_000) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got %b expected %b", i, obs, 8'b00001_000);
      end
    end
  endtask

  task automatic test_up_trip();
    logic [4:0] req [5] = '{5'b00100, 5'b00100, 5'b00100, 5'b00000, 5'b00000};
    logic [7:0] exp [5] = '{8'b00001_010, 8'b00010_010, 8'b00100_100,
                            8'b00100_100, 8'b00100_000};
    for (int i = 0; i < 5; i++) begin
      bus.floor_req = req[i];
      tick();
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL up_trip[%0d]: got %b expected %b", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_down_trip();
    logic [4:0] req [15] = '{5'b00010, 5'b0, 5'b0, 5'b0,
                             5'b01000, 5'b0, 5'b0, 5'b0, 5'b0,
                             5'b00001, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0};
    logic [7:0] exp [15] = '{8'b00100_001, 8'b00010_100, 8'b00010_100, 8'b00010_000,
                             8'b00010_010, 8'b00100_010, 8'b01000_100, 8'b01000_100,
                             8'b01000_000,
                             8'b01000_001, 8'b00100_001, 8'b00010_001, 8'b00001_100,
                             8'b00001_100, 8'b00001_000};
    for (int i = 0; i < 15; i++) begin
      bus.floor_req = req[i];
      tick();
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL down_trip[%0d]: got %b expected %b", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_full_span();
    logic [4:0] req [9] = '{5'b10000, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0};
    logic [7:0] exp [9] = '{8'b00001_010, 8'b00010_010, 8'b00100_010, 8'b01000_010,
                            8'b10000_100, 8'b10000_100, 8'b10000_000, 8'b10000_000,
                            8'b10000_000};
    for (int i = 0; i < 9; i++) begin
      bus.floor_req = req[i];
      tick();
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL full_span[%0d]: got %b expected %b", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_scan();
    logic [4:0] req [11] = '{5'b01010, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0,
                             5'b0, 5'b0, 5'b0, 5'b0, 5'b0};
    logic [7:0] exp [11] = '{8'b00001_010, 8'b00010_100, 8'b00010_100, 8'b00010_010,
                             8'b00100_010, 8'b01000_100, 8'b01000_100, 8'b01000_000,
                             8'b01000_000, 8'b01000_000, 8'b01000_000};
    rst = 1'b0;
    #2;
    rst = 1'b1;
    for (int i = 0; i < 11; i++) begin
      bus.floor_req = req[i];
      tick();
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL scan[%0d]: got %b expected %b", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_dir_pref();
    logic [4:0] req [11] = '{5'b01000, 5'b0, 5'b00001, 5'b0, 5'b0, 5'b0,
                             5'b0, 5'b0, 5'b0, 5'b0, 5'b0};
    logic [7:0] exp [11] = '{8'b00001_010, 8'b00010_010, 8'b00100_010, 8'b01000_100,
                             8'b01000_100, 8'b01000_001, 8'b00100_001, 8'b00010_001,
                             8'b00001_100, 8'b00001_100, 8'b00001_000};
    rst = 1'b0;
    #2;
    rst = 1'b1;
    for (int i = 0; i < 11; i++) begin
      bus.floor_req = req[i];
      tick();
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL dir_pref[%0d]: got %b expected %b", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_door_hold();
    logic [4:0] req [5] = '{5'b00001, 5'b00001, 5'b00001, 5'b00000, 5'b00000};
    logic [7:0] exp [5] = '{8'b00001_100, 8'b00001_100, 8'b00001_100,
                            8'b00001_100, 8'b00001_000};
    for (int i = 0; i < 5; i++) begin
      bus.floor_req = req[i];
      tick();
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL door_hold[%0d]: got %b expected %b", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] req [3] = '{5'b10000, 5'b0, 5'b0};
    logic [7:0] exp [3] = '{8'b00001_010, 8'b00010_010, 8'b00100_010};
    rst = 1'b0;
    #2;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.floor_req = req[i];
      tick();
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL async_pre[%0d]: got %b expected %b", i, obs, exp[i]);
      end
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== 8'b00001_000) begin
      errors++;
      $display("FAIL async_now: got %b expected %b", obs, 8'b00001_000);
    end
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs !== 8'b00001_000) begin
        errors++;
        $display("FAIL async_after[%0d]: got %b expected %b", i, obs, 8'b00001_000);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    bus.floor_req = 5'b00000;
    tick();
    test_reset();
    test_up_trip();
    test_down_trip();
    test_full_span();
    test_scan();
    test_dir_pref();
    test_door_hold();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
